// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, packet-locked, burst-limited share of the UART TX write port
module uart_tx_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 16,
  localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1,
  localparam int CW = MAX_BURST > 1 ? $clog2(MAX_BURST) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      wr_en,
  output logic [DATA_W-1:0]         d_in,
  input  logic                      tx_full,
  output logic                      grant_valid,
  output logic [IW-1:0]             grant_id
);
  typedef enum logic {IDLE, GRANT} state_e;
  state_e          state_q, state_d;
  logic [IW-1:0]   rr_q, rr_d, gid_q, gid_d, pick, j;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            found, xfer;
  // first valid requester scanning from rr_q; reverse loop so the smallest offset wins
  always_comb begin
    found = 1'b0;
    pick  = '0;
    j     = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = IW'((int'(rr_q) + k) % NUM_REQ);
      if (req_valid[j]) begin
        found = 1'b1;
        pick  = j;
      end
    end
  end
  // next state and write-side outputs; the owner keeps the lock until last byte or burst limit
  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    gid_d     = gid_q;
    cnt_d     = cnt_q;
    req_ready = '0;
    wr_en     = 1'b0;
    d_in      = '0;
    xfer      = (state_q == GRANT) && req_valid[gid_q] && !tx_full;
    if (state_q == IDLE) begin
      if (found) begin
        gid_d   = pick;
        cnt_d   = '0;
        state_d = GRANT;
      end
    end else begin
      req_ready[gid_q] = !tx_full;
      wr_en            = xfer;
      d_in             = xfer ? req_data[int'(gid_q)*DATA_W +: DATA_W] : '0;
      if (xfer) begin
        if (req_last[gid_q] || cnt_q == CW'(MAX_BURST - 1)) begin
          state_d = IDLE;
          rr_d    = gid_q == IW'(NUM_REQ - 1) ? '0 : gid_q + IW'(1);
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    end
  end
  // state registers; async reset aborts any packet in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      rr_q    <= '0;
      gid_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      gid_q   <= gid_d;
      cnt_q   <= cnt_d;
    end
  end
  assign grant_valid = state_q == GRANT;
  assign grant_id    = gid_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: scoreboard bench with a packet-level round-robin reference model
module tb_uart_tx_arbiter;
  localparam int N = 4, W = 8, MB = 4;
  logic           clk = 1'b0, reset = 1'b0, tx_full = 1'b0;
  logic [N-1:0]   req_valid = '0, req_last = '0, req_ready;
  logic [N*W-1:0] req_data = '0;
  logic           wr_en, grant_valid;
  logic [W-1:0]   d_in;
  logic [1:0]     grant_id;
  int             checks = 0, failures = 0, model_rr = 0;
  logic [8:0]     pq [N][$];
  logic [8:0]     mq [N][$];
  logic [11:0]    exp_q [$];
  bit             bubble = 0, tx_rand = 0, tx_hold = 0, drop_rand = 0;
  logic [N-1:0]   drop_force = '0;

  uart_tx_arbiter #(.NUM_REQ(N), .DATA_W(W), .MAX_BURST(MB)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .wr_en(wr_en), .d_in(d_in),
    .tx_full(tx_full), .grant_valid(grant_valid), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", n, a, e);
    end
  endtask

  task automatic add_byte(int id, logic [7:0] b, bit last);
    pq[id].push_back({last, b});
    mq[id].push_back({last, b});
  endtask

  task automatic add_pkt(int id, int len);
    for (int k = 0; k < len; k++) add_byte(id, 8'($urandom), k == len - 1);
  endtask

  // packets leave in round-robin order, each grant ending at its last byte or after MB bytes
  task automatic run_model();
    int id, n;
    bit rel;
    logic [8:0] e;
    forever begin
      id = -1;
      for (int k = N - 1; k >= 0; k--) if (mq[(model_rr + k) % N].size() > 0) id = (model_rr + k) % N;
      if (id < 0) break;
      n = 0;
      rel = 0;
      while (!rel && mq[id].size() > 0) begin
        e = mq[id].pop_front();
        n++;
        rel = e[8] || n == MB;
        exp_q.push_back({rel, 3'(id), e[7:0]});
      end
      model_rr = (id + 1) % N;
    end
  endtask

  function automatic bit all_empty();
    all_empty = exp_q.size() == 0;
    for (int i = 0; i < N; i++) if (pq[i].size() > 0) all_empty = 0;
  endfunction

  task automatic clear_all();
    for (int i = 0; i < N; i++) begin
      pq[i].delete();
      mq[i].delete();
    end
    exp_q.delete();
    model_rr = 0;
    bubble = 0;
  endtask

  task automatic sync_rst();
    reset = 1'b0;
    clear_all();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic drain(string n);
    int c = 0;
    while (!all_empty() && c < 2000) begin
      @(posedge clk);
      c++;
    end
    chk({n, " drained"}, c < 2000, 1);
    repeat (3) @(posedge clk);
  endtask

  task automatic wait_exp(int n);
    int c = 0;
    while (exp_q.size() > n && c < 500) begin
      @(negedge clk);
      #1;
      c++;
    end
    chk("wait_exp bound", c < 500, 1);
  endtask

  // requester side: retire accepted bytes, present queue heads, apply tx_full and owner drops
  initial begin
    logic [N-1:0] acc;
    logic [8:0] h;
    bit has, drop;
    forever begin
      @(negedge clk);
      acc = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) if (acc[i] && pq[i].size() > 0) void'(pq[i].pop_front());
      tx_full = tx_hold || (tx_rand && $urandom_range(0, 2) == 0);
      for (int i = 0; i < N; i++) begin
        has  = pq[i].size() > 0;
        h    = has ? pq[i][0] : 9'h0;
        drop = grant_valid && grant_id == 2'(i) && (drop_force[i] || (drop_rand && $urandom_range(0, 3) == 0));
        req_valid[i]       = has && !drop;
        req_last[i]        = h[8];
        req_data[i*W +: W] = h[7:0];
      end
    end
  end

  // monitor: every write must be the next model byte from the expected owner
  initial begin
    logic [11:0] e;
    forever begin
      @(negedge clk);
      if (reset) begin
        if (bubble) chk("idle bubble", grant_valid, 0);
        bubble = 0;
        if (tx_full) chk("stall gating", {wr_en, req_ready}, 0);
        if (wr_en) begin
          if (exp_q.size() == 0) chk("unexpected write", d_in, 32'hffff_ffff);
          else begin
            e = exp_q.pop_front();
            chk("wr d_in", d_in, e[7:0]);
            chk("wr owner", grant_id, e[10:8]);
            chk("wr ready", req_ready[grant_id] && grant_valid, 1);
            bubble = e[11];
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    #12;
    chk("rst grant_valid", grant_valid, 0);
    chk("rst wr_en", wr_en, 0);
    chk("rst req_ready", req_ready, 0);
    chk("rst d_in", d_in, 0);
    @(negedge clk);
    reset = 1'b1;
    add_byte(0, 8'hA1, 0);
    add_byte(0, 8'hA2, 0);
    add_byte(0, 8'hA3, 1);
    run_model();
    @(posedge clk);
    #2;
    @(negedge clk);
    chk("t1 arb latency", grant_valid, 0);
    @(negedge clk);
    chk("t1 grant_valid", grant_valid, 1);
    chk("t1 grant_id", grant_id, 0);
    drain("t1");
    add_pkt(0, 2);
    add_pkt(1, 2);
    run_model();
    drain("t1 rr");
    sync_rst();
    add_byte(0, 8'h10, 1);
    add_byte(1, 8'h20, 1);
    add_byte(2, 8'h30, 1);
    add_byte(3, 8'h40, 1);
    add_byte(0, 8'h50, 1);
    run_model();
    drain("t2");
    sync_rst();
    add_pkt(1, 6);
    add_pkt(2, 2);
    run_model();
    drain("t3");
    sync_rst();
    add_byte(0, 8'h55, 0);
    add_byte(0, 8'h66, 0);
    add_byte(0, 8'h77, 1);
    run_model();
    wait_exp(2);
    @(posedge clk);
    #2;
    tx_hold = 1;
    repeat (5) @(posedge clk);
    #2;
    tx_hold = 0;
    drain("t4");
    sync_rst();
    add_pkt(0, 5);
    add_pkt(3, 2);
    run_model();
    wait_exp(5);
    drop_force[0] = 1'b1;
    repeat (3) @(posedge clk);
    drop_force = '0;
    drain("t5");
    sync_rst();
    add_pkt(0, 4);
    run_model();
    wait_exp(2);
    @(posedge clk);
    #3;
    chk("t6 pre-reset wr_en", wr_en, 1);
    reset = 1'b0;
    #1;
    chk("t6 async wr_en", wr_en, 0);
    chk("t6 async req_ready", req_ready, 0);
    chk("t6 async grant_valid", grant_valid, 0);
    chk("t6 async d_in", d_in, 0);
    clear_all();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    add_byte(2, 8'hC2, 1);
    add_byte(0, 8'hC0, 1);
    run_model();
    drain("t6");
    sync_rst();
    tx_rand = 1;
    drop_rand = 1;
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 2)) add_pkt(i, $urandom_range(1, 7));
      run_model();
      drain("rand");
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
